// File: rtl/cpu_pkg.sv
// Shared constants for the teaching-CPU datapath: bus width and ALU opcodes.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         opcode,
    input  logic               inc_pc,
    output logic [2*WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [SHW-1:0]            amt;
    logic [2*WIDTH-1:0]        dbl;
    logic [2*WIDTH-1:0]        dbl_r;
    logic [2*WIDTH-1:0]        dbl_l;
    logic [WIDTH-1:0]          quo;
    logic [WIDTH-1:0]          rem;

    assign a_s   = a;
    assign b_s   = b;
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Rotates are taken from a doubled copy of A so no wrap logic is needed
    assign amt   = b[SHW-1:0];
    assign dbl   = {a, a};
    assign dbl_r = dbl >> amt;
    assign dbl_l = dbl << amt;

    // Signed divide; zero divisor and the MIN/-1 overflow case get defined results
    always_comb begin
        quo = '0;
        rem = '0;
        if (b == '0) begin
            quo = '1;
            rem = a;
        end else if (b == '1) begin
            quo = -a;
            rem = '0;
        end else begin
            quo = a_s / b_s;
            rem = a_s % b_s;
        end
    end

    // Operation select; IncPC wins over the opcode so the PC increment is always available
    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[WIDTH-1:0] = b + WIDTH'(1);
        end else begin
            case (opcode)
                OP_ADD:  result[WIDTH-1:0] = a + b;
                OP_SUB:  result[WIDTH-1:0] = a - b;
                OP_AND:  result[WIDTH-1:0] = a & b;
                OP_OR:   result[WIDTH-1:0] = a | b;
                OP_SHR:  result[WIDTH-1:0] = a >> amt;
                OP_SHRA: result[WIDTH-1:0] = a_s >>> amt;
                OP_SHL:  result[WIDTH-1:0] = a << amt;
                OP_ROR:  result[WIDTH-1:0] = dbl_r[WIDTH-1:0];
                OP_ROL:  result[WIDTH-1:0] = dbl_l[2*WIDTH-1:WIDTH];
                OP_MUL:  result            = prod;
                OP_DIV:  result            = {rem, quo};
                OP_NEG:  result[WIDTH-1:0] = -b;
                OP_NOT:  result[WIDTH-1:0] = ~b;
                default: result            = '0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus datapath: register file, special registers, Z, bus mux and ALU.
// Sequencing comes from outside; this block has no state machine.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH   // fixed at 32; Z is 2*WIDTH
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             Read,
    input  logic             IncPC,
    input  logic [4:0]       opcode,
    input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             HIin, LOin, Yin, Zhighin, Zlowin,
    input  logic             PCin, IRin, MARin, MDRin, Inportin, Cin,
    input  logic             R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIout, LOout, Yout, Zhighout, Zlowout,
    input  logic             PCout, IRout, MARout, MDRout, Inportout, Cout,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPort_data,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] PC_q
);

    logic [15:0]          r_in;
    logic [15:0]          r_out;
    logic [WIDTH-1:0]     bus;
    logic [2*WIDTH-1:0]   alu_res;

    logic [WIDTH-1:0]     gpr_q [16];
    logic [WIDTH-1:0]     gpr_d [16];
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [WIDTH-1:0]     pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]     inport_q, inport_d, c_q, c_d;
    logic [2*WIDTH-1:0]   z_q, z_d;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Bus mux: assignments run lowest priority first, so the last match (R0 side) wins
    always_comb begin
        bus = '0;
        if (MARout)    bus = mar_q;
        if (IRout)     bus = ir_q;
        if (Yout)      bus = y_q;
        if (Cout)      bus = c_q;
        if (Inportout) bus = inport_q;
        if (MDRout)    bus = mdr_q;
        if (PCout)     bus = pc_q;
        if (Zlowout)   bus = z_q[WIDTH-1:0];
        if (Zhighout)  bus = z_q[2*WIDTH-1:WIDTH];
        if (LOout)     bus = lo_q;
        if (HIout)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = gpr_q[i];
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (opcode),
        .inc_pc (IncPC),
        .result (alu_res)
    );

    // Next-state for every register: hold unless its load strobe is high
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            gpr_d[i] = r_in[i] ? bus : gpr_q[i];
        end
        hi_d     = HIin     ? bus : hi_q;
        lo_d     = LOin     ? bus : lo_q;
        y_d      = Yin      ? bus : y_q;
        pc_d     = PCin     ? bus : pc_q;
        ir_d     = IRin     ? bus : ir_q;
        mar_d    = MARin    ? bus : mar_q;
        c_d      = Cin      ? bus : c_q;
        mdr_d    = MDRin    ? (Read ? Mdatain : bus) : mdr_q;
        inport_d = Inportin ? InPort_data : inport_q;
        z_d      = {Zhighin ? alu_res[2*WIDTH-1:WIDTH] : z_q[2*WIDTH-1:WIDTH],
                    Zlowin  ? alu_res[WIDTH-1:0]       : z_q[WIDTH-1:0]};
    end

    // Register bank with asynchronous active-low clear
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            c_q      <= '0;
            z_q      <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            inport_q <= inport_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    assign BusMuxOut = bus;
    assign MAR_q     = mar_q;
    assign IR_q      = ir_q;
    assign PC_q      = pc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: register transfers, fetch, ALU ops, bus priority, reset.
module tb_cpu_datapath;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        clear;
    logic        Read, IncPC;
    logic [4:0]  opcode;
    logic [15:0] rin, rout;
    logic        HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin, MDRin, Inportin, Cin;
    logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout;
    logic [31:0] Mdatain, InPort_data;
    logic [31:0] BusMuxOut, MAR_q, IR_q, PC_q;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    cpu_datapath dut (
        .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
        .Inportout(Inportout), .Cout(Cout),
        .Mdatain(Mdatain), .InPort_data(InPort_data),
        .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q), .PC_q(PC_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Read = 0; IncPC = 0; opcode = 5'b0; rin = '0; rout = '0;
        HIin = 0; LOin = 0; Yin = 0; Zhighin = 0; Zlowin = 0;
        PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Inportin = 0; Cin = 0;
        HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0;
        PCout = 0; IRout = 0; MARout = 0; MDRout = 0; Inportout = 0; Cout = 0;
    endtask

    // One clock edge, then sample point 1 time unit later with controls dropped
    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    // Caller has raised the Xout strobe(s); let the bus settle and compare
    task automatic bus_is(input string tag, input logic [31:0] exp);
        #1;
        check(tag, BusMuxOut, exp);
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        step();
    endtask

    task automatic read_gpr(input int idx, input logic [31:0] exp, input string tag);
        rout[idx] = 1;
        bus_is(tag, exp);
    endtask

    // Y <= a, then bus = b through MDR with both Z halves loading, then read Z back
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic inc, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input string tag);
        mem_to_mdr(a);
        MDRout = 1; Yin = 1;
        step();
        mem_to_mdr(b);
        MDRout = 1; opcode = op; IncPC = inc; Zlowin = 1; Zhighin = 1;
        step();
        Zlowout = 1;
        bus_is({tag, "_lo"}, exp_lo);
        Zhighout = 1;
        bus_is({tag, "_hi"}, exp_hi);
    endtask

    initial begin
        clear = 0;
        Mdatain = '0;
        InPort_data = '0;
        idle();
        #1;
        check("rst_bus", BusMuxOut, 32'h0);
        check("rst_pc",  PC_q,      32'h0);
        check("rst_mar", MAR_q,     32'h0);
        check("rst_ir",  IR_q,      32'h0);
        #10 clear = 1;
        @(posedge Clock);
        #1;

        // GPR loads from memory through MDR
        mem_to_mdr(32'd8);
        MDRout = 1; rin[2] = 1;
        step();
        read_gpr(2, 32'd8, "r2_load");
        mem_to_mdr(32'd9);
        MDRout = 1; rin[3] = 1;
        step();
        read_gpr(3, 32'd9, "r3_load");
        mem_to_mdr(32'h18);
        MDRout = 1; rin[1] = 1;
        step();
        read_gpr(1, 32'h18, "r1_load");

        // Instruction fetch
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
        step();
        check("fetch_mar", MAR_q, 32'h0);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h18918000;
        #1;
        check("fetch_zlo", BusMuxOut, 32'h1);
        step();
        check("fetch_pc", PC_q, 32'h1);
        MDRout = 1; IRin = 1;
        step();
        check("fetch_ir", IR_q, 32'h18918000);
        PCout = 1; MARin = 1;
        step();
        check("mar_from_pc", MAR_q, 32'h1);

        // add R1, R2, R3
        rout[2] = 1; Yin = 1;
        step();
        rout[3] = 1; opcode = OP_ADD; Zlowin = 1;
        step();
        Zlowout = 1; rin[1] = 1;
        step();
        read_gpr(1, 32'h11, "add_r1");

        // ALU operations
        alu_op(32'hFFFF_FFFD, 32'd7, OP_MUL, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, "mul_neg");
        alu_op(32'd7,         32'd2, OP_DIV, 1'b0, 32'd3,         32'd1,         "div_7_2");
        alu_op(32'hFFFF_FFF9, 32'd2, OP_DIV, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        alu_op(32'd7,         32'd0, OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd7,         "div_zero");
        alu_op(32'hFFFF_FFFF, 32'd2, OP_ADD, 1'b0, 32'd1,         32'd0,         "add_wrap");
        alu_op(32'd0,         32'd1, OP_SUB, 1'b0, 32'hFFFF_FFFF, 32'd0,         "sub_wrap");
        alu_op(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b0, 32'hF000_F000, 32'd0, "and");
        alu_op(32'hF0F0_F0F0, 32'hFF00_FF00, OP_OR,  1'b0, 32'hFFF0_FFF0, 32'd0, "or");
        alu_op(32'h8000_00F1, 32'd4, OP_SHR,  1'b0, 32'h0800_000F, 32'd0, "shr");
        alu_op(32'h8000_00F1, 32'd4, OP_SHRA, 1'b0, 32'hF800_000F, 32'd0, "shra");
        alu_op(32'h8000_00F1, 32'd4, OP_SHL,  1'b0, 32'h0000_0F10, 32'd0, "shl");
        alu_op(32'h8000_00F1, 32'd4, OP_ROR,  1'b0, 32'h1800_000F, 32'd0, "ror");
        alu_op(32'h8000_00F1, 32'd4, OP_ROL,  1'b0, 32'h0000_0F18, 32'd0, "rol");
        alu_op(32'h8000_00F1, 32'h24, OP_SHL, 1'b0, 32'h0000_0F10, 32'd0, "shl_amt5");
        alu_op(32'd0,         32'd5, OP_NEG,  1'b0, 32'hFFFF_FFFB, 32'd0, "neg");
        alu_op(32'd0,         32'd0, OP_NOT,  1'b0, 32'hFFFF_FFFF, 32'd0, "not");
        alu_op(32'd5,         32'd3, 5'b00000, 1'b0, 32'd0,        32'd0, "bad_op");
        alu_op(32'd5,         32'd41, OP_MUL, 1'b1, 32'd42,        32'd0, "incpc_ovr");

        // Bus priority and idle bus
        bus_is("bus_none", 32'h0);
        rout[1] = 1; rout[2] = 1;
        bus_is("bus_r1_r2", 32'h11);
        mem_to_mdr(32'hCAFE_0000);
        MDRout = 1; HIin = 1;
        step();
        HIout = 1; LOout = 1;
        bus_is("bus_hi_lo", 32'hCAFE_0000);
        HIout = 1; rout[15] = 1;
        bus_is("bus_r15_hi", 32'h0);
        MDRout = 1; PCout = 1;
        bus_is("bus_pc_mdr", 32'h1);

        // Inport takes the port value, not the bus
        InPort_data = 32'h1234_5678; Inportin = 1; rout[1] = 1;
        step();
        Inportout = 1;
        bus_is("inport", 32'h1234_5678);
        rout[3] = 1; Cin = 1;
        step();
        Cout = 1;
        bus_is("c_load", 32'd9);

        // MDR from the bus when Read is low
        Mdatain = 32'hDEAD_BEEF; rout[1] = 1; MDRin = 1; Read = 0;
        step();
        MDRout = 1;
        bus_is("mdr_bus", 32'h11);

        // Same register driving and loading holds its value
        rout[3] = 1; rin[3] = 1;
        step();
        read_gpr(3, 32'd9, "self_load");

        // Asynchronous clear mid-cycle
        #2;
        clear = 0;
        #1;
        check("clr_pc",  PC_q,  32'h0);
        check("clr_mar", MAR_q, 32'h0);
        check("clr_ir",  IR_q,  32'h0);
        rout[1] = 1;
        bus_is("clr_r1", 32'h0);
        HIout = 1;
        bus_is("clr_hi", 32'h0);
        clear = 1;
        step();
        mem_to_mdr(32'h55);
        MDRout = 1; rin[4] = 1;
        step();
        read_gpr(4, 32'h55, "post_clr_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
